// File: rtl/alu_arb_pkg.sv
// Shared types and sizes for the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned N_REQ    = 2;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  always_comb begin
    any = |req_valid;
    if (&req_valid) begin
      grant = ~last;
    end else begin
      grant = req_valid[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one fixed-latency ALU between two valid/ready requesters, one operation in flight,
// round-robin on contention, result returned over a per-requester valid/ready channel.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned data_width  = 32,
  parameter int unsigned alu_latency = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*data_width-1:0]  req_A,
  input  logic [N_REQ*data_width-1:0]  req_B,
  input  logic [N_REQ*ALU_OP_W-1:0]    req_op,
  output logic [N_REQ-1:0]             resp_valid,
  input  logic [N_REQ-1:0]             resp_ready,
  output logic [data_width-1:0]        resp_R,
  output logic                         resp_flag,
  output logic [data_width-1:0]        alu_A,
  output logic [data_width-1:0]        alu_B,
  output logic [ALU_OP_W-1:0]          alu_op,
  input  logic [data_width-1:0]        alu_R,
  input  logic                         alu_flag
);

  localparam int unsigned cnt_w = (alu_latency > 1) ? $clog2(alu_latency + 1) : 1;

  state_e           state_q, state_d;
  logic             last_q;
  logic             gnt_q;
  logic [cnt_w-1:0] cnt_q;
  logic             pick;
  logic             any;
  logic             accept;
  logic             capture;

  rr_arb2 u_rr (
    .req_valid (req_valid),
    .last      (last_q),
    .grant     (pick),
    .any       (any)
  );

  // Gated by rst so nothing is offered while reset is being applied.
  assign accept  = (state_q == StIdle) && any && !rst;
  assign capture = (state_q == StBusy) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StBusy;
      StBusy:  if (capture) state_d = StResp;
      StResp:  if (resp_ready[gnt_q]) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (accept) begin
      req_ready = pick ? 2'b10 : 2'b01;
    end
    if (state_q == StResp) begin
      resp_valid = gnt_q ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      cnt_q     <= '0;
      alu_A     <= '0;
      alu_B     <= '0;
      alu_op    <= '0;
      resp_R    <= '0;
      resp_flag <= 1'b0;
    end else begin
      if (accept) begin
        alu_A  <= pick ? req_A[2*data_width-1:data_width] : req_A[data_width-1:0];
        alu_B  <= pick ? req_B[2*data_width-1:data_width] : req_B[data_width-1:0];
        alu_op <= pick ? req_op[2*ALU_OP_W-1:ALU_OP_W] : req_op[ALU_OP_W-1:0];
        last_q <= pick;
        gnt_q  <= pick;
        cnt_q  <= cnt_w'(alu_latency);
      end
      if (state_q == StBusy) begin
        if (capture) begin
          resp_R    <= alu_R;
          resp_flag <= alu_flag;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: latency-1 and latency-4 instances, each with a registered ALU stub.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_A;
  logic [63:0] req_B;
  logic [7:0]  req_op;
  logic [1:0]  resp_ready;

  logic [1:0]  req_ready1, resp_valid1;
  logic [31:0] resp_R1, alu_A1, alu_B1, alu_R1;
  logic        resp_flag1, alu_flag1;
  logic [3:0]  alu_op1;

  logic [1:0]  req_ready4, resp_valid4;
  logic [31:0] resp_R4, alu_A4, alu_B4, alu_R4;
  logic        resp_flag4, alu_flag4;
  logic [3:0]  alu_op4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.data_width(32), .alu_latency(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
    .req_A(req_A), .req_B(req_B), .req_op(req_op),
    .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_R(resp_R1), .resp_flag(resp_flag1),
    .alu_A(alu_A1), .alu_B(alu_B1), .alu_op(alu_op1), .alu_R(alu_R1), .alu_flag(alu_flag1)
  );

  alu_arbiter #(.data_width(32), .alu_latency(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4),
    .req_A(req_A), .req_B(req_B), .req_op(req_op),
    .resp_valid(resp_valid4), .resp_ready(resp_ready), .resp_R(resp_R4), .resp_flag(resp_flag4),
    .alu_A(alu_A4), .alu_B(alu_B4), .alu_op(alu_op4), .alu_R(alu_R4), .alu_flag(alu_flag4)
  );

  function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    if (op == 4'd0) return {1'b0, a} + {1'b0, b};
    return {1'b0, a - b};
  endfunction

  // ALU stubs: one register stage for dut1, four for dut4.
  logic [32:0] p4 [4];
  always @(posedge clk) begin
    {alu_flag1, alu_R1} <= alu_f(alu_A1, alu_B1, alu_op1);
    p4[0] <= alu_f(alu_A4, alu_B4, alu_op4);
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign {alu_flag4, alu_R4} = p4[3];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    req_A[i*32 +: 32] = a;
    req_B[i*32 +: 32] = b;
    req_op[i*4 +: 4]  = op;
  endtask

  task automatic do_reset;
    rst        = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    req_A      = '0;
    req_B      = '0;
    req_op     = '0;
    resp_ready = 2'b00;
    req_valid  = 2'b11;
    tick();
    tick();
    n_checks++; if (req_ready1 !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready1); end
    n_checks++; if (resp_valid1 !== 2'b00) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid1); end
    n_checks++; if (resp_R1 !== 32'd0 || resp_flag1 !== 1'b0) begin n_fail++; $display("FAIL reset_resp_data: got %h/%b want 0/0", resp_R1, resp_flag1); end
    n_checks++; if (alu_A1 !== 32'd0 || alu_B1 !== 32'd0 || alu_op1 !== 4'd0) begin n_fail++; $display("FAIL reset_alu: got %h %h %h want 0 0 0", alu_A1, alu_B1, alu_op1); end
    n_checks++; if (req_ready4 !== 2'b00 || alu_A4 !== 32'd0) begin n_fail++; $display("FAIL reset_dut4: got %b %h want 00 0", req_ready4, alu_A4); end
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready1 !== 2'b01) begin n_fail++; $display("FAIL reset_first_tie: got %b want 01", req_ready1); end
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_single;
    do_reset();
    set_req(0, 32'd5, 32'd7, 4'd0);
    req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready1 !== 2'b01) begin n_fail++; $display("FAIL single_req_ready: got %b want 01", req_ready1); end
    tick();
    req_valid = 2'b00;
    n_checks++; if (alu_A1 !== 32'd5 || alu_B1 !== 32'd7) begin n_fail++; $display("FAIL single_alu_operands: got %0d %0d want 5 7", alu_A1, alu_B1); end
    tick();
    n_checks++; if (resp_valid1 !== 2'b00) begin n_fail++; $display("FAIL single_early_resp: got %b want 00", resp_valid1); end
    tick();
    n_checks++; if (resp_valid1 !== 2'b01) begin n_fail++; $display("FAIL single_resp_valid: got %b want 01", resp_valid1); end
    n_checks++; if (resp_R1 !== 32'd12 || resp_flag1 !== 1'b0) begin n_fail++; $display("FAIL single_result: got %0d/%b want 12/0", resp_R1, resp_flag1); end
    resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00;
    n_checks++; if (resp_valid1 !== 2'b00) begin n_fail++; $display("FAIL single_resp_drop: got %b want 00", resp_valid1); end
  endtask

  task automatic test_overflow;
    do_reset();
    set_req(1, 32'hFFFF_FFFF, 32'd1, 4'd0);
    req_valid = 2'b10;
    #1;
    n_checks++; if (req_ready1 !== 2'b10) begin n_fail++; $display("FAIL overflow_req_ready: got %b want 10", req_ready1); end
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    n_checks++; if (resp_valid1 !== 2'b10) begin n_fail++; $display("FAIL overflow_resp_valid: got %b want 10", resp_valid1); end
    n_checks++; if (resp_R1 !== 32'd0 || resp_flag1 !== 1'b1) begin n_fail++; $display("FAIL overflow_result: got %h/%b want 0/1", resp_R1, resp_flag1); end
    // Wrong-side ready must not release the response.
    resp_ready = 2'b01;
    tick();
    n_checks++; if (resp_valid1 !== 2'b10) begin n_fail++; $display("FAIL overflow_ignore_other_ready: got %b want 10", resp_valid1); end
    resp_ready = 2'b00;
  endtask

  task automatic test_contention;
    do_reset();
    set_req(0, 32'd1, 32'd2, 4'd0);
    set_req(1, 32'd10, 32'd20, 4'd0);
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = 0;
      while (req_ready1 === 2'b00 && c < 12) begin
        n_checks++; if (resp_valid1 === 2'b11) begin n_fail++; $display("FAIL contention_resp_onehot: got %b want not 11", resp_valid1); end
        if (resp_valid1 === 2'b01) begin
          n_checks++; if (resp_R1 !== 32'd3) begin n_fail++; $display("FAIL contention_r0: got %0d want 3", resp_R1); end
        end
        if (resp_valid1 === 2'b10) begin
          n_checks++; if (resp_R1 !== 32'd30) begin n_fail++; $display("FAIL contention_r1: got %0d want 30", resp_R1); end
        end
        tick();
        c++;
      end
      n_checks++;
      if (req_ready1 !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL contention_grant op %0d: got %b want %b", k, req_ready1,
                 (k % 2 == 1) ? 2'b10 : 2'b01);
      end
      tick();
    end
    req_valid  = 2'b00;
    resp_ready = 2'b00;
  endtask

  task automatic test_backpressure;
    do_reset();
    set_req(0, 32'd100, 32'd23, 4'd0);
    set_req(1, 32'd40, 32'd2, 4'd1);
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready1 !== 2'b01) begin n_fail++; $display("FAIL bp_first_grant: got %b want 01", req_ready1); end
    tick();
    req_valid = 2'b10;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (resp_valid1 !== 2'b01) begin n_fail++; $display("FAIL bp_resp_valid cycle %0d: got %b want 01", i, resp_valid1); end
      n_checks++; if (resp_R1 !== 32'd123) begin n_fail++; $display("FAIL bp_resp_R cycle %0d: got %0d want 123", i, resp_R1); end
      n_checks++; if (req_ready1 !== 2'b00) begin n_fail++; $display("FAIL bp_req_ready cycle %0d: got %b want 00", i, req_ready1); end
      tick();
    end
    resp_ready = 2'b01;
    #1;
    n_checks++; if (req_ready1 !== 2'b00) begin n_fail++; $display("FAIL bp_ready_in_resp: got %b want 00", req_ready1); end
    tick();
    resp_ready = 2'b00;
    #1;
    n_checks++; if (req_ready1 !== 2'b10) begin n_fail++; $display("FAIL bp_next_grant: got %b want 10", req_ready1); end
    tick();
    req_valid = 2'b00;
    n_checks++; if (alu_op1 !== 4'd1 || alu_A1 !== 32'd40) begin n_fail++; $display("FAIL bp_op_passthrough: got %h %0d want 1 40", alu_op1, alu_A1); end
    tick();
    tick();
    n_checks++; if (resp_valid1 !== 2'b10 || resp_R1 !== 32'd38) begin n_fail++; $display("FAIL bp_second_result: got %b %0d want 10 38", resp_valid1, resp_R1); end
  endtask

  task automatic test_reset_busy;
    do_reset();
    set_req(0, 32'd3, 32'd4, 4'd5);
    req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready1 !== 2'b01) begin n_fail++; $display("FAIL rb_accept: got %b want 01", req_ready1); end
    tick();
    req_valid = 2'b00;
    n_checks++; if (alu_op1 !== 4'd5 || alu_A1 !== 32'd3) begin n_fail++; $display("FAIL rb_alu_loaded: got %h %0d want 5 3", alu_op1, alu_A1); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (resp_valid1 !== 2'b00 || req_ready1 !== 2'b00) begin n_fail++; $display("FAIL rb_handshake_zero: got %b %b want 00 00", resp_valid1, req_ready1); end
    n_checks++; if (resp_R1 !== 32'd0 || resp_flag1 !== 1'b0) begin n_fail++; $display("FAIL rb_resp_zero: got %h/%b want 0/0", resp_R1, resp_flag1); end
    n_checks++; if (alu_A1 !== 32'd0 || alu_B1 !== 32'd0 || alu_op1 !== 4'd0) begin n_fail++; $display("FAIL rb_alu_zero: got %h %h %h want 0 0 0", alu_A1, alu_B1, alu_op1); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (resp_valid1 !== 2'b00) begin n_fail++; $display("FAIL rb_no_resp cycle %0d: got %b want 00", i, resp_valid1); end
    end
    set_req(0, 32'd9, 32'd6, 4'd0);
    req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready1 !== 2'b01) begin n_fail++; $display("FAIL rb_new_accept: got %b want 01", req_ready1); end
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    n_checks++; if (resp_valid1 !== 2'b01 || resp_R1 !== 32'd15) begin n_fail++; $display("FAIL rb_new_result: got %b %0d want 01 15", resp_valid1, resp_R1); end
  endtask

  task automatic test_latency4;
    do_reset();
    set_req(1, 32'd7, 32'd8, 4'd0);
    req_valid = 2'b10;
    #1;
    n_checks++; if (req_ready4 !== 2'b10) begin n_fail++; $display("FAIL l4_accept: got %b want 10", req_ready4); end
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (alu_A4 !== 32'd7 || alu_B4 !== 32'd8 || alu_op4 !== 4'd0) begin n_fail++; $display("FAIL l4_alu_stable cycle %0d: got %0d %0d %h want 7 8 0", i, alu_A4, alu_B4, alu_op4); end
      n_checks++; if (resp_valid4 !== 2'b00) begin n_fail++; $display("FAIL l4_early_resp cycle %0d: got %b want 00", i, resp_valid4); end
      tick();
    end
    n_checks++; if (resp_valid4 !== 2'b10) begin n_fail++; $display("FAIL l4_resp_valid: got %b want 10", resp_valid4); end
    n_checks++; if (resp_R4 !== 32'd15 || resp_flag4 !== 1'b0) begin n_fail++; $display("FAIL l4_result: got %0d/%b want 15/0", resp_R4, resp_flag4); end
    resp_ready = 2'b10;
    tick();
    resp_ready = 2'b00;
    n_checks++; if (resp_valid4 !== 2'b00) begin n_fail++; $display("FAIL l4_resp_drop: got %b want 00", resp_valid4); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_contention();
    test_backpressure();
    test_reset_busy();
    test_latency4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
